// File: rtl/spi_master_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_master_engine: byte-wide mode-0 SPI master, one-entry TX buffer     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module spi_master_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] toXmit,
  input  logic       strobe,
  input  logic [1:0] ss_sel,
  output logic [7:0] Rcvd,
  output logic       Ready,
  output logic       XmitFull,
  output logic       busy,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic [1:0] ss
);

  localparam int CW = $clog2(CLK_DIV + 1);

  generate
    if (CLK_DIV < 1) begin : g_div_check
      $error("spi_master_engine: CLK_DIV must be 1 or more");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    half_q, half_d;
  logic [7:0]    tx_q, tx_d, rx_q, rx_d;
  logic [1:0]    ss_q, ss_d;
  logic          sck_q, sck_d;
  logic [7:0]    buf_byte_q, buf_byte_d;
  logic [1:0]    buf_ss_q, buf_ss_d;
  logic          full_q, full_d;
  logic [7:0]    rcvd_q, rcvd_d;
  logic          ready_q, ready_d;
  logic          last_w;

  assign last_w = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    buf_byte_d = buf_byte_q;
    buf_ss_d   = buf_ss_q;
    full_d     = full_q;
    rcvd_d     = rcvd_q;
    ready_d    = 1'b0;

    // A full buffer drops the strobe, so this never collides with the IDLE drain.
    if (strobe && !full_q) begin
      buf_byte_d = toXmit;
      buf_ss_d   = ss_sel;
      full_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        half_d = '0;
        sck_d  = 1'b0;
        if (full_q) begin
          tx_d    = buf_byte_q;
          ss_d    = buf_ss_q;
          full_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (last_w) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (last_w) begin
          cnt_d  = '0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], miso};
          end else begin
            sck_d = 1'b0;
            tx_d  = {tx_q[6:0], 1'b0};
          end
          if (half_q == 4'd15) begin
            half_d  = '0;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (last_w) begin
          cnt_d   = '0;
          rcvd_d  = rx_q;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ss_q       <= 2'b11;
      sck_q      <= 1'b0;
      buf_byte_q <= '0;
      buf_ss_q   <= 2'b11;
      full_q     <= 1'b0;
      rcvd_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      buf_byte_q <= buf_byte_d;
      buf_ss_q   <= buf_ss_d;
      full_q     <= full_d;
      rcvd_q     <= rcvd_d;
      ready_q    <= ready_d;
    end
  end

  assign Rcvd     = rcvd_q;
  assign Ready    = ready_q;
  assign XmitFull = full_q;
  assign busy     = (state_q != IDLE);
  assign mosi     = tx_q[7];
  assign sck      = sck_q;
  assign ss       = (state_q == IDLE) ? 2'b11 : ss_q;

endmodule
`default_nettype wire
